// File: rtl/axi_tmr_fault_injector_if.sv
// Replica bus between the signal source, the injector and the TMR voter bank.
// master: source/voter side; slave: the injector that produces the replicas.
interface axi_tmr_fault_injector_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [2:0]       err_lane;

   modport master (output d_in, output err_lane, input d0, input d1, input d2);
   modport slave  (input d_in, input err_lane, output d0, output d1, output d2);
endinterface

// File: rtl/axi_tmr_fault_injector.sv
// Triplicates a source word and flips one bit of one replica on a programmed
// schedule, then checks the voter's per-lane error flags against that lane.
//
// state  | meaning
// IDLE   | replicas pass through, waiting for start
// WAIT   | counting down the inter-injection delay
// INJECT | one cycle: bit flip applied to the selected replica
// DONE   | one cycle: campaign finished, done pulses
module axi_tmr_fault_injector #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                     aclk,
   input  logic                     areset,
   axi_tmr_fault_injector_if.slave  bus,
   input  logic                     start,
   input  logic                     abort,
   input  logic [1:0]               cfg_lane,
   input  logic [$clog2(WIDTH)-1:0] cfg_bit,
   input  logic [CNT_W-1:0]         cfg_delay,
   input  logic [CNT_W-1:0]         cfg_num,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         inj_count,
   output logic [CNT_W-1:0]         miss_count
);
   localparam int BIT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT, S_DONE} state_t;

   state_t             state;
   logic [1:0]         lane_q;
   logic [BIT_W-1:0]   bit_q;
   logic [CNT_W-1:0]   delay_q;
   logic [CNT_W-1:0]   dly_cnt;
   logic [CNT_W-1:0]   rem_cnt;
   logic [1:0]         rot_ptr;
   logic               pend;
   logic [2:0]         exp_lane;

   logic [1:0]         cur_lane;
   logic [WIDTH-1:0]   flip;
   logic [WIDTH-1:0]   mask0;
   logic [WIDTH-1:0]   mask1;
   logic [WIDTH-1:0]   mask2;

   assign cur_lane = (lane_q == 2'd3) ? rot_ptr : lane_q;

   // An out-of-range bit index yields no flip, but the injection is still
   // scheduled, counted and checked like any other.
   always_comb begin
      flip  = '0;
      mask0 = '0;
      mask1 = '0;
      mask2 = '0;
      if (int'(bit_q) < WIDTH) flip[bit_q] = 1'b1;
      if (state == S_INJECT) begin
         case (cur_lane)
            2'd0:    mask0 = flip;
            2'd1:    mask1 = flip;
            2'd2:    mask2 = flip;
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         bus.d0     <= '0;
         bus.d1     <= '0;
         bus.d2     <= '0;
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         inj_count  <= '0;
         miss_count <= '0;
         lane_q     <= '0;
         bit_q      <= '0;
         delay_q    <= '0;
         dly_cnt    <= '0;
         rem_cnt    <= '0;
         rot_ptr    <= '0;
         pend       <= 1'b0;
         exp_lane   <= '0;
      end else begin
         bus.d0 <= bus.d_in ^ mask0;
         bus.d1 <= bus.d_in ^ mask1;
         bus.d2 <= bus.d_in ^ mask2;
         done   <= 1'b0;

         // The flip and its count land even when abort hits the INJECT cycle.
         if (state == S_INJECT) begin
            if (inj_count != '1) inj_count <= inj_count + 1'b1;
            if (lane_q == 2'd3) rot_ptr <= (rot_ptr == 2'd2) ? 2'd0 : rot_ptr + 2'd1;
         end

         if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pend  <= 1'b0;
         end else begin
            if (pend) begin
               if (bus.err_lane != exp_lane && miss_count != '1)
                  miss_count <= miss_count + 1'b1;
               pend <= 1'b0;
            end
            case (state)
               S_IDLE: begin
                  if (start) begin
                     lane_q  <= cfg_lane;
                     bit_q   <= cfg_bit;
                     delay_q <= cfg_delay;
                     dly_cnt <= cfg_delay;
                     rem_cnt <= (cfg_num == '0) ? CNT_W'(1) : cfg_num;
                     rot_ptr <= 2'd0;
                     state   <= S_WAIT;
                     busy    <= 1'b1;
                  end
               end
               S_WAIT: begin
                  if (dly_cnt == '0) state <= S_INJECT;
                  else               dly_cnt <= dly_cnt - 1'b1;
               end
               S_INJECT: begin
                  pend     <= 1'b1;
                  exp_lane <= 3'b001 << cur_lane;
                  rem_cnt  <= rem_cnt - 1'b1;
                  if (rem_cnt == CNT_W'(1)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_WAIT;
                     dly_cnt <= delay_q;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_axi_tmr_fault_injector.sv
// Directed bench: per-cycle replica/done/busy expectations go through a
// scoreboard queue; a behavioural majority voter closes the err_lane loop.
module tb_axi_tmr_fault_injector;
   localparam int WIDTH = 32;
   localparam int CNT_W = 8;

   typedef struct {
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        dn;
      logic        bz;
   } exp_t;

   logic             aclk;
   logic             areset;
   logic             start;
   logic             abort;
   logic [1:0]       cfg_lane;
   logic [4:0]       cfg_bit;
   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_num;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] inj_count;
   logic [CNT_W-1:0] miss_count;
   logic             force_miss;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   axi_tmr_fault_injector_if #(.WIDTH(WIDTH)) intf ();

   axi_tmr_fault_injector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .aclk       (aclk),
      .areset     (areset),
      .bus        (intf.slave),
      .start      (start),
      .abort      (abort),
      .cfg_lane   (cfg_lane),
      .cfg_bit    (cfg_bit),
      .cfg_delay  (cfg_delay),
      .cfg_num    (cfg_num),
      .busy       (busy),
      .done       (done),
      .inj_count  (inj_count),
      .miss_count (miss_count)
   );

   // Behavioural voter bank: a lane is in error where it disagrees with the majority.
   logic [31:0] maj;
   assign maj = (intf.d0 & intf.d1) | (intf.d0 & intf.d2) | (intf.d1 & intf.d2);
   assign intf.err_lane = force_miss ? 3'b000 :
                          {|(intf.d2 ^ maj), |(intf.d1 ^ maj), |(intf.d0 ^ maj)};

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle; lane >= 0 means the DUT should be in INJECT this cycle.
   task automatic tick_exp(input logic [31:0] din, input int lane, input int bitn,
                           input logic e_done, input logic e_busy);
      exp_t e;
      logic [31:0] m;
      m = (lane >= 0) ? (32'h1 << bitn) : 32'h0;
      e.e0 = din ^ ((lane == 0) ? m : 32'h0);
      e.e1 = din ^ ((lane == 1) ? m : 32'h0);
      e.e2 = din ^ ((lane == 2) ? m : 32'h0);
      e.dn = e_done;
      e.bz = e_busy;
      intf.d_in = din;
      sb.push_back(e);
      @(posedge aclk);
      #1;
      e = sb.pop_front();
      chk("d0", 64'(intf.d0), 64'(e.e0));
      chk("d1", 64'(intf.d1), 64'(e.e1));
      chk("d2", 64'(intf.d2), 64'(e.e2));
      chk("done", 64'(done), 64'(e.dn));
      chk("busy", 64'(busy), 64'(e.bz));
   endtask

   task automatic counters(input string tag, input int e_inj, input int e_miss);
      chk({tag, "_inj"}, 64'(inj_count), 64'(e_inj));
      chk({tag, "_miss"}, 64'(miss_count), 64'(e_miss));
   endtask

   task automatic setup(input logic [1:0] l, input logic [4:0] b,
                        input logic [CNT_W-1:0] dl, input logic [CNT_W-1:0] n);
      cfg_lane = l; cfg_bit = b; cfg_delay = dl; cfg_num = n;
   endtask

   initial begin
      areset = 1'b1; start = 1'b0; abort = 1'b0; force_miss = 1'b0;
      setup(2'd0, 5'd0, '0, '0);
      intf.d_in = 32'hDEAD_BEEF;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_d0", 64'(intf.d0), 64'h0);
      chk("rst_d1", 64'(intf.d1), 64'h0);
      chk("rst_d2", 64'(intf.d2), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      counters("rst", 0, 0);
      areset = 1'b0;

      // passthrough
      tick_exp(32'hA5A5_0F0F, -1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick_exp($urandom, -1, 0, 1'b0, 1'b0);
      counters("pass", 0, 0);

      // single injection: lane 1, bit 4, delay 3
      setup(2'd1, 5'd4, 8'd3, 8'd1);
      start = 1'b1;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      setup(2'd2, 5'd9, 8'd7, 8'd9);
      repeat (4) tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      tick_exp(32'h0, 1, 4, 1'b1, 1'b1);
      chk("single_d1", 64'(intf.d1), 64'h10);
      tick_exp(32'h0, -1, 0, 1'b0, 1'b0);
      counters("single", 1, 0);

      // rotate campaign: lanes 0,1,2,0
      setup(2'd3, 5'd17, 8'd0, 8'd4);
      start = 1'b1;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
         tick_exp(32'h0, k % 3, 17, (k == 3), 1'b1);
      end
      tick_exp(32'h0, -1, 0, 1'b0, 1'b0);
      counters("rotate", 5, 0);

      // miss detection: voter reports nothing in the check cycle
      setup(2'd2, 5'd31, 8'd1, 8'd1);
      start = 1'b1;
      tick_exp(32'h5555_AAAA, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      repeat (2) tick_exp(32'h5555_AAAA, -1, 0, 1'b0, 1'b1);
      tick_exp(32'h5555_AAAA, 2, 31, 1'b1, 1'b1);
      force_miss = 1'b1;
      tick_exp(32'h5555_AAAA, -1, 0, 1'b0, 1'b0);
      force_miss = 1'b0;
      counters("miss", 6, 1);

      // abort in WAIT after two injections of a five-injection campaign
      setup(2'd0, 5'd7, 8'd2, 8'd5);
      start = 1'b1;
      tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      repeat (3) tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b1);
      tick_exp(32'h1234_5678, 0, 7, 1'b0, 1'b1);
      repeat (3) tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b1);
      tick_exp(32'h1234_5678, 0, 7, 1'b0, 1'b1);
      tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b1);
      abort = 1'b1;
      tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b0);
      abort = 1'b0;
      repeat (10) tick_exp(32'h1234_5678, -1, 0, 1'b0, 1'b0);
      counters("abort", 8, 1);

      // cfg_num = 0 behaves as one injection
      setup(2'd1, 5'd0, 8'd0, 8'd0);
      start = 1'b1;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      tick_exp(32'h0, 1, 0, 1'b1, 1'b1);
      tick_exp(32'h0, -1, 0, 1'b0, 1'b0);
      repeat (3) tick_exp(32'h0, -1, 0, 1'b0, 1'b0);
      counters("num0", 9, 1);

      // start together with abort stays idle
      setup(2'd0, 5'd1, 8'd0, 8'd1);
      start = 1'b1; abort = 1'b1;
      tick_exp(32'hCAFE_F00D, -1, 0, 1'b0, 1'b0);
      start = 1'b0; abort = 1'b0;
      repeat (4) tick_exp(32'hCAFE_F00D, -1, 0, 1'b0, 1'b0);
      counters("startabort", 9, 1);

      // saturation: every injection missed, counters pinned at all-ones
      setup(2'd3, 5'd9, 8'd0, 8'd255);
      force_miss = 1'b1;
      start = 1'b1;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      for (int k = 0; k < 255; k++) begin
         tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
         tick_exp(32'h0, k % 3, 9, (k == 254), 1'b1);
      end
      tick_exp(32'h0, -1, 0, 1'b0, 1'b0);
      force_miss = 1'b0;
      counters("sat", 255, 255);

      // reset asserted in the INJECT cycle
      setup(2'd2, 5'd3, 8'd0, 8'd3);
      start = 1'b1;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      start = 1'b0;
      tick_exp(32'h0, -1, 0, 1'b0, 1'b1);
      areset = 1'b1;
      intf.d_in = 32'hFFFF_0000;
      @(posedge aclk);
      #1;
      chk("rstinj_d0", 64'(intf.d0), 64'h0);
      chk("rstinj_d1", 64'(intf.d1), 64'h0);
      chk("rstinj_d2", 64'(intf.d2), 64'h0);
      chk("rstinj_busy", 64'(busy), 64'h0);
      chk("rstinj_done", 64'(done), 64'h0);
      counters("rstinj", 0, 0);
      areset = 1'b0;
      repeat (3) tick_exp(32'h0F0F_F0F0, -1, 0, 1'b0, 1'b0);
      counters("post", 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
